line_addr_sequencer: RTL and testbench

- Inverse of the cache address parser: rebuilds a full memory address from tag, index and byte_select.
- Issues the per-beat addresses of one cache-line transfer (fill or writeback) to the memory interface through a valid/ready handshake.
- Sits between the cache controller (request side) and the memory bus model (beat side).
- Fills are critical-word-first with wrap-around; writebacks run in ascending order from beat 0.

---
 rtl/line_addr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_line_addr_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/line_addr_sequencer.sv
// line_addr_sequencer
//   Rebuilds a full memory address from a cache line's tag and index, then
//   issues the per-beat addresses of one line transfer to the memory side
//   over a valid/ready handshake. Fills start at the critical word and wrap
//   around the line; writebacks run in ascending order from beat 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake from the cache controller
//   req_wb            1 = writeback, 0 = fill
//   req_tag/index     line identity
//   req_byte_select   requested byte offset (critical word for fills)
//   mem_valid/ready   beat handshake to the memory bus model
//   mem_addr          beat-aligned byte address
//   mem_we            latched req_wb
//   mem_beat          beat number within the line
//   mem_last          final beat of the transfer
//   done              one-cycle pulse after the final beat handshake
module line_addr_sequencer #(
  parameter int i_size     = 64,
  parameter int d_size     = 6,
  parameter int c_size     = 14,
  parameter int a_size     = 8,
  parameter int beat_bytes = 8,
  localparam int index_bits = c_size - $clog2(a_size) - d_size,
  localparam int tag_bits   = i_size - index_bits - d_size,
  localparam int beats      = (2 ** d_size) / beat_bytes,
  localparam int bb         = $clog2(beat_bytes),
  localparam int bw         = (beats > 1) ? $clog2(beats) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic [tag_bits-1:0]   req_tag,
  input  logic [index_bits-1:0] req_index,
  input  logic [d_size-1:0]     req_byte_select,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [i_size-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [bw-1:0]         mem_beat,
  output logic                  mem_last,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [bw-1:0] last_cnt = bw'(beats - 1);

  state_t                  state_q, state_d;
  logic [tag_bits-1:0]     tag_q, tag_d;
  logic [index_bits-1:0]   index_q, index_d;
  logic                    we_q, we_d;
  logic [bw-1:0]           beat_q, beat_d;
  logic [bw-1:0]           cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;

  logic [bw-1:0]           start_fill;
  logic [bw-1:0]           beat_inc;
  logic [bw-1:0]           cnt_inc;
  logic [i_size-1:0]       line_base;
  logic                    unused_bsel;

  // Critical beat of a fill: the byte offset with its within-beat bits dropped.
  // With a single beat per line there is nothing to select.
  generate
    if (beats > 1) begin : g_multi_beat
      assign start_fill = req_byte_select[d_size-1:bb];
    end else begin : g_single_beat
      assign start_fill = '0;
    end
  endgenerate

  // The within-beat offset bits are intentionally ignored.
  assign unused_bsel = ^req_byte_select;

  // Beat counter wraps modulo the line length (beats is a power of two).
  assign beat_inc = (beats == 1) ? '0 : beat_q + bw'(1);
  assign cnt_inc  = cnt_q + bw'(1);

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    index_d = index_q;
    we_d    = we_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        if (req_valid && ready_q) begin
          tag_d   = req_tag;
          index_d = req_index;
          we_d    = req_wb;
          beat_d  = req_wb ? '0 : start_fill;
          cnt_d   = '0;
          ready_d = 1'b0;
          valid_d = 1'b1;
          last_d  = (last_cnt == '0);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (valid_q && mem_ready) begin
          beat_d = beat_inc;
          cnt_d  = cnt_inc;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            last_d = (cnt_inc == last_cnt);
          end
        end
      end
      DONE: begin
        // done_q is high during this state; the next request is taken in IDLE.
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Line base has zero offset bits, so OR-ing in the beat offset never carries.
  assign line_base = {tag_q, index_q, {d_size{1'b0}}};
  assign mem_addr  = line_base | (i_size'(beat_q) << bb);

  assign req_ready = ready_q;
  assign mem_valid = valid_q;
  assign mem_we    = we_q;
  assign mem_beat  = beat_q;
  assign mem_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_line_addr_sequencer.sv
module tb_line_addr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wb;
  logic [52:0] req_tag;
  logic [4:0]  req_index;
  logic [5:0]  req_byte_select;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_beat;
  logic        mem_last;
  logic        done;

  int n_vec;
  int n_fail;

  typedef struct {
    logic             wb;
    logic [52:0]      tag;
    logic [4:0]       idx;
    logic [5:0]       bsel;
    int               stall_at;  // beat position to hold mem_ready low, -1 = none
    int               stall_n;
    logic [0:7][63:0] addr;      // expected addresses in issue order
  } vec_t;

  vec_t vecs[5];
  vec_t vec_busy_a, vec_busy_b, vec_after_rst;

  line_addr_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wb          (req_wb),
    .req_tag         (req_tag),
    .req_index       (req_index),
    .req_byte_select (req_byte_select),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_beat        (mem_beat),
    .mem_last        (mem_last),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one complete transfer starting from an IDLE negedge. With keep_req
  // set, a different request (nxt) is held on the request port while busy.
  task automatic do_xfer(input vec_t v, input bit keep_req, input vec_t nxt);
    logic [63:0] ea;
    req_valid       = 1'b1;
    req_wb          = v.wb;
    req_tag         = v.tag;
    req_index       = v.idx;
    req_byte_select = v.bsel;
    mem_ready       = 1'b0;
    chk("idle_req_ready", {63'b0, req_ready}, 64'd1);
    @(negedge clk);
    if (keep_req) begin
      req_wb          = nxt.wb;
      req_tag         = nxt.tag;
      req_index       = nxt.idx;
      req_byte_select = nxt.bsel;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      ea = v.addr[i];
      if (i == v.stall_at) begin
        mem_ready = 1'b0;
        for (int s = 0; s < v.stall_n; s++) begin
          chk("stall_valid", {63'b0, mem_valid}, 64'd1);
          chk("stall_addr", mem_addr, ea);
          chk("stall_beat", {61'b0, mem_beat}, {61'b0, ea[5:3]});
          @(negedge clk);
        end
      end
      mem_ready = 1'b1;
      chk("beat_valid", {63'b0, mem_valid}, 64'd1);
      chk("beat_addr", mem_addr, ea);
      chk("beat_num", {61'b0, mem_beat}, {61'b0, ea[5:3]});
      chk("beat_we", {63'b0, mem_we}, {63'b0, v.wb});
      chk("beat_last", {63'b0, mem_last}, (i == 7) ? 64'd1 : 64'd0);
      if (keep_req) chk("busy_req_ready", {63'b0, req_ready}, 64'd0);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    chk("done_pulse", {63'b0, done}, 64'd1);
    chk("done_valid", {63'b0, mem_valid}, 64'd0);
    chk("done_req_ready", {63'b0, req_ready}, 64'd0);
    @(negedge clk);
    chk("done_clear", {63'b0, done}, 64'd0);
    chk("idle_again", {63'b0, req_ready}, 64'd1);
    $display("xfer wb=%0d tag=0x%0h index=0x%0h bsel=0x%0h first=0x%0h stall_at=%0d",
             v.wb, v.tag, v.idx, v.bsel, v.addr[0], v.stall_at);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    // Fill, defaults: base 0x8C0, critical beat 5.
    vecs[0] = '{wb: 1'b0, tag: 53'h1, idx: 5'h3, bsel: 6'h28, stall_at: -1, stall_n: 0,
                addr: {64'h8E8, 64'h8F0, 64'h8F8, 64'h8C0, 64'h8C8, 64'h8D0, 64'h8D8, 64'h8E0}};
    // Writeback: base 0xFFC0, ascending from beat 0 regardless of byte_select.
    vecs[1] = '{wb: 1'b1, tag: 53'h1F, idx: 5'h1F, bsel: 6'h3C, stall_at: -1, stall_n: 0,
                addr: {64'hFFC0, 64'hFFC8, 64'hFFD0, 64'hFFD8, 64'hFFE0, 64'hFFE8, 64'hFFF0, 64'hFFF8}};
    // Unaligned critical word at the last beat: starts at +0x38, wraps to base.
    vecs[2] = '{wb: 1'b0, tag: 53'h2, idx: 5'h0, bsel: 6'h3F, stall_at: -1, stall_n: 0,
                addr: {64'h1038, 64'h1000, 64'h1008, 64'h1010, 64'h1018, 64'h1020, 64'h1028, 64'h1030}};
    // Backpressure on the third beat for 3 cycles; base 0x2A80, start beat 2.
    vecs[3] = '{wb: 1'b0, tag: 53'h5, idx: 5'h0A, bsel: 6'h10, stall_at: 2, stall_n: 3,
                addr: {64'h2A90, 64'h2A98, 64'h2AA0, 64'h2AA8, 64'h2AB0, 64'h2AB8, 64'h2A80, 64'h2A88}};
    // All-ones tag writeback exercises the top address bits.
    vecs[4] = '{wb: 1'b1, tag: 53'h1F_FFFF_FFFF_FFFF, idx: 5'h0, bsel: 6'h00, stall_at: -1, stall_n: 0,
                addr: {64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_F808, 64'hFFFF_FFFF_FFFF_F810,
                       64'hFFFF_FFFF_FFFF_F818, 64'hFFFF_FFFF_FFFF_F820, 64'hFFFF_FFFF_FFFF_F828,
                       64'hFFFF_FFFF_FFFF_F830, 64'hFFFF_FFFF_FFFF_F838}};
    vec_busy_a = vecs[0];
    // Writeback tag 7 index 1: base 0x3840.
    vec_busy_b = '{wb: 1'b1, tag: 53'h7, idx: 5'h1, bsel: 6'h00, stall_at: -1, stall_n: 0,
                   addr: {64'h3840, 64'h3848, 64'h3850, 64'h3858, 64'h3860, 64'h3868, 64'h3870, 64'h3878}};
    // Fill tag 2 index 0 at byte 0x18: base 0x1000, start beat 3.
    vec_after_rst = '{wb: 1'b0, tag: 53'h2, idx: 5'h0, bsel: 6'h18, stall_at: -1, stall_n: 0,
                      addr: {64'h1018, 64'h1020, 64'h1028, 64'h1030, 64'h1038, 64'h1000, 64'h1008, 64'h1010}};

    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_wb          = 1'b0;
    req_tag         = '0;
    req_index       = '0;
    req_byte_select = '0;
    mem_ready       = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_mem_valid", {63'b0, mem_valid}, 64'd0);
    chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
    chk("rst_mem_last", {63'b0, mem_last}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_beat", {61'b0, mem_beat}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_valid", {63'b0, mem_valid}, 64'd0);

    for (int k = 0; k < 5; k++) do_xfer(vecs[k], 1'b0, vecs[k]);

    // Busy request held through a whole transfer, then taken afterwards.
    do_xfer(vec_busy_a, 1'b1, vec_busy_b);
    do_xfer(vec_busy_b, 1'b0, vec_busy_b);

    // Reset after the third handshake of a fill.
    req_valid       = 1'b1;
    req_wb          = 1'b0;
    req_tag         = 53'h1;
    req_index       = 5'h3;
    req_byte_select = 6'h28;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("prerst_addr", mem_addr, vecs[0].addr[i]);
      @(negedge clk);
    end
    chk("prerst_pending", mem_addr, 64'h8C0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'b0, mem_valid}, 64'd0);
    chk("midrst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("midrst_addr", mem_addr, 64'd0);
    chk("midrst_beat", {61'b0, mem_beat}, 64'd0);
    chk("midrst_last", {63'b0, mem_last}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    chk("midrst_done_hold", {63'b0, done}, 64'd0);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("postrst_valid", {63'b0, mem_valid}, 64'd0);
    chk("postrst_done", {63'b0, done}, 64'd0);
    $display("xfer abandoned by reset after 3 beats");
    do_xfer(vec_after_rst, 1'b0, vec_after_rst);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
